// File: rtl/periph_sched.sv
// periph_sched: round-robin time-slot scheduler that shares one start/mix
// datapath between two peripherals. A pending request is granted for
// max(run_len,1) cycles. The slot's first cycle is marked with a one-cycle
// slot_start pulse. A grant-free GAP cycle always separates two slots.
// Completed slots are counted in slot_cnt. Counter-wrap pulses from the
// peripherals are collected into sticky, individually clearable irq bits.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             scheduler enable (level)
//   run_len [RUN_W]   slot length, 0 treated as 1, latched in ARB
//   req     [2]       per-peripheral slot request (level)
//   wrap_in [2]       per-peripheral counter-wrap pulse
//   irq_clr [2]       per-bit clear of irq_pending
//   grant   [2]       one-hot grant, 0 outside RUN
//   slot_start [2]    pulse on the first RUN cycle
//   busy              high in ARB, RUN and GAP
//   slot_cnt [CNT_W]  completed-slot counter, wraps
//   irq_pending [2]   sticky wrap flags
//   irq_any           registered OR of irq_pending
module periph_sched #(
    parameter int RUN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RUN_W-1:0] run_len,
    input  logic [1:0]       req,
    input  logic [1:0]       wrap_in,
    input  logic [1:0]       irq_clr,
    output logic [1:0]       grant,
    output logic [1:0]       slot_start,
    output logic             busy,
    output logic [CNT_W-1:0] slot_cnt,
    output logic [1:0]       irq_pending,
    output logic             irq_any
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic             win_q, win_d;
    logic             last_q, last_d;
    logic [RUN_W-1:0] cnt_q, cnt_d;
    logic [1:0]       grant_q, grant_d;
    logic [1:0]       ss_q, ss_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       irq_q, irq_d;
    logic             irq_any_q, irq_any_d;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        slot_cnt_d = slot_cnt_q;
        ss_d       = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (start && (|req)) state_d = S_ARB;
            end
            S_ARB: begin
                if (req == 2'b00) begin
                    state_d = S_IDLE;
                end else begin
                    // Both pending: hand the slot to whoever did not have the last one.
                    win_d   = (req == 2'b11) ? ~last_q : req[1];
                    cnt_d   = (run_len == '0) ? RUN_W'(1) : run_len;
                    state_d = S_RUN;
                    ss_d    = win_d ? 2'b10 : 2'b01;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - RUN_W'(1);
                // cnt_q==1 means this edge takes the counter to zero.
                if ((cnt_q == RUN_W'(1)) || !req[win_q]) begin
                    state_d    = S_GAP;
                    last_d     = win_q;
                    slot_cnt_d = slot_cnt_q + CNT_W'(1);
                end
            end
            default: begin // S_GAP
                state_d = (start && (|req)) ? S_ARB : S_IDLE;
            end
        endcase
        // Outputs are registered from the next state so they line up with it.
        grant_d = (state_d == S_RUN) ? (win_d ? 2'b10 : 2'b01) : 2'b00;
        busy_d  = (state_d != S_IDLE);
    end

    // Set wins over clear in the same cycle.
    assign irq_d     = (irq_q & ~irq_clr) | wrap_in;
    assign irq_any_d = |irq_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            win_q      <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            grant_q    <= 2'b00;
            ss_q       <= 2'b00;
            busy_q     <= 1'b0;
            slot_cnt_q <= '0;
            irq_q      <= 2'b00;
            irq_any_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            ss_q       <= ss_d;
            busy_q     <= busy_d;
            slot_cnt_q <= slot_cnt_d;
            irq_q      <= irq_d;
            irq_any_q  <= irq_any_d;
        end
    end

    assign grant       = grant_q;
    assign slot_start  = ss_q;
    assign busy        = busy_q;
    assign slot_cnt    = slot_cnt_q;
    assign irq_pending = irq_q;
    assign irq_any     = irq_any_q;

endmodule

// File: tb/tb_periph_sched.sv
// Directed bench for periph_sched. Per-cycle expectations for the slot
// outputs go into a queue as stimulus is applied. They are popped and
// compared one per clock.
module tb_periph_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] run_len;
    logic [1:0] req, wrap_in, irq_clr;
    logic [1:0] grant, slot_start, irq_pending;
    logic       busy, irq_any;
    logic [7:0] slot_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] g;
        logic [1:0] s;
        logic       b;
        logic [7:0] c;
    } exp_t;

    exp_t sb[$];

    periph_sched #(.RUN_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .run_len(run_len), .req(req),
        .wrap_in(wrap_in), .irq_clr(irq_clr), .grant(grant),
        .slot_start(slot_start), .busy(busy), .slot_cnt(slot_cnt),
        .irq_pending(irq_pending), .irq_any(irq_any)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] g, input logic [1:0] s, input logic b, input logic [7:0] c);
        exp_t e;
        e.g = g; e.s = s; e.b = b; e.c = c;
        sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        while (sb.size() > 0) begin
            tick();
            e = sb.pop_front();
            chk({tag, ".grant"}, 32'(grant), 32'(e.g));
            chk({tag, ".slot_start"}, 32'(slot_start), 32'(e.s));
            chk({tag, ".busy"}, 32'(busy), 32'(e.b));
            chk({tag, ".slot_cnt"}, 32'(slot_cnt), 32'(e.c));
        end
    endtask

    // Hold reset for two edges with the given stimulus already applied, then release.
    task automatic do_reset(input logic st, input logic [1:0] rq, input logic [3:0] rl);
        rst = 1'b1; start = st; req = rq; run_len = rl;
        wrap_in = 2'b00; irq_clr = 2'b00;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; req = 2'b00; run_len = 4'd0;
        wrap_in = 2'b00; irq_clr = 2'b00;
        #1;
        chk("reset.grant", 32'(grant), 0);
        chk("reset.busy", 32'(busy), 0);
        chk("reset.slot_cnt", 32'(slot_cnt), 0);
        chk("reset.irq", 32'(irq_pending), 0);
        chk("reset.irq_any", 32'(irq_any), 0);

        // Single requester, run_len=3, two slots.
        do_reset(1'b1, 2'b01, 4'd3);
        push(2'b00, 2'b00, 1, 0);
        push(2'b01, 2'b01, 1, 0);
        push(2'b01, 2'b00, 1, 0);
        push(2'b01, 2'b00, 1, 0);
        push(2'b00, 2'b00, 1, 1);
        push(2'b00, 2'b00, 1, 1);
        push(2'b01, 2'b01, 1, 1);
        drain("single");

        // Round-robin with both requesting, run_len=2: period 4.
        do_reset(1'b1, 2'b11, 4'd2);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] w;
            w = (k % 2 == 0) ? 2'b01 : 2'b10;
            push(2'b00, 2'b00, 1, 8'(k));
            push(w, w, 1, 8'(k));
            push(w, 2'b00, 1, 8'(k));
            push(2'b00, 2'b00, 1, 8'(k + 1));
        end
        drain("rr");

        // run_len=0 gives one-cycle grants.
        do_reset(1'b1, 2'b01, 4'd0);
        push(2'b00, 2'b00, 1, 0);
        push(2'b01, 2'b01, 1, 0);
        push(2'b00, 2'b00, 1, 1);
        push(2'b00, 2'b00, 1, 1);
        push(2'b01, 2'b01, 1, 1);
        push(2'b00, 2'b00, 1, 2);
        drain("len0");

        // Early end: drop req[0] in the 2nd cycle of a run_len=8 slot.
        do_reset(1'b1, 2'b01, 4'd8);
        push(2'b00, 2'b00, 1, 0);
        push(2'b01, 2'b01, 1, 0);
        drain("early.pre");
        req = 2'b00;
        push(2'b00, 2'b00, 1, 1);
        push(2'b00, 2'b00, 0, 1);
        push(2'b00, 2'b00, 0, 1);
        drain("early.post");

        // start held low: nothing is granted.
        do_reset(1'b0, 2'b11, 4'd2);
        for (int k = 0; k < 4; k++) push(2'b00, 2'b00, 0, 0);
        drain("nostart");

        // start dropped during RUN does not abort the slot.
        do_reset(1'b1, 2'b10, 4'd3);
        push(2'b00, 2'b00, 1, 0);
        push(2'b10, 2'b10, 1, 0);
        drain("stoprun.pre");
        start = 1'b0;
        push(2'b10, 2'b00, 1, 0);
        push(2'b10, 2'b00, 1, 0);
        push(2'b00, 2'b00, 1, 1);
        push(2'b00, 2'b00, 0, 1);
        drain("stoprun.post");

        // 256 back-to-back run_len=1 slots: one slot every 3 cycles.
        do_reset(1'b1, 2'b01, 4'd1);
        for (int k = 0; k < 765; k++) tick();
        chk("wrap.cnt255", 32'(slot_cnt), 32'hFF);
        for (int k = 0; k < 3; k++) tick();
        chk("wrap.cnt0", 32'(slot_cnt), 0);

        // Interrupts.
        do_reset(1'b0, 2'b00, 4'd0);
        wrap_in = 2'b10;
        tick();
        wrap_in = 2'b00;
        chk("irq.set", 32'(irq_pending), 32'h2);
        chk("irq.any_lag", 32'(irq_any), 0);
        tick();
        chk("irq.any", 32'(irq_any), 1);
        wrap_in = 2'b10; irq_clr = 2'b10;
        tick();
        wrap_in = 2'b00; irq_clr = 2'b00;
        chk("irq.set_wins", 32'(irq_pending), 32'h2);
        irq_clr = 2'b10;
        tick();
        irq_clr = 2'b00;
        chk("irq.clr", 32'(irq_pending), 0);
        chk("irq.any_hold", 32'(irq_any), 1);
        tick();
        chk("irq.any_clr", 32'(irq_any), 0);

        // Reset mid-slot clears everything asynchronously.
        do_reset(1'b1, 2'b10, 4'd5);
        wrap_in = 2'b01;
        push(2'b00, 2'b00, 1, 0);
        drain("midrst.arb");
        wrap_in = 2'b00;
        tick();
        chk("midrst.grant_pre", 32'(grant), 32'h2);
        chk("midrst.ss_pre", 32'(slot_start), 32'h2);
        chk("midrst.irq_pre", 32'(irq_pending), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst.grant", 32'(grant), 0);
        chk("midrst.ss", 32'(slot_start), 0);
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.cnt", 32'(slot_cnt), 0);
        chk("midrst.irq", 32'(irq_pending), 0);
        req = 2'b11;
        tick();
        rst = 1'b0;
        push(2'b00, 2'b00, 1, 0);
        push(2'b01, 2'b01, 1, 0);
        drain("midrst.after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/periph_sched.md
# periph_sched

Time-slot scheduler that shares the SoC's single start/mix datapath between the two peripherals (periph0, periph1) of the soc_top hierarchy. Pending requests are granted round-robin, one slot at a time, for a programmable slot length. Each slot start is sequenced with a one-cycle pulse. Completed slots are counted, and counter-wrap events from each peripheral's counter are collected into sticky, individually clearable interrupt bits.

## Interface
Parameters:
- RUN_W, 4, width of the slot-length input.
- CNT_W, 8, width of the completed-slot counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  scheduler enable (level); no new slot is granted while low.
- run_len  in  RUN_W  slot length in cycles; 0 is treated as 1; latched in ARB.
- req  in  2  per-peripheral slot request (level).
- wrap_in  in  2  per-peripheral counter-wrap pulse.
- irq_clr  in  2  per-bit clear for irq_pending.
- grant  out  2  one-hot grant; all zeros when no slot is active.
- slot_start  out  2  one-cycle pulse on the first cycle of a slot.
- busy  out  1  high in ARB, RUN and GAP.
- slot_cnt  out  CNT_W  number of completed slots; wraps.
- irq_pending  out  2  sticky wrap flags.
- irq_any  out  1  registered OR of irq_pending.

## Operation
All outputs are registered. Reset forces every output to 0, the FSM to IDLE, and the round-robin pointer `last` to 1, so requester 0 wins the first arbitration. Reset clears all of this immediately and mid-slot, without waiting for a clock edge.

FSM states:
- IDLE: grant=0, busy=0.
  - start && |req → ARB.
- ARB (exactly 1 cycle): busy=1.
  - Winner: the single requester if only one req bit is set; if both are set, the requester ≠ last.
  - Latch the winner and max(run_len,1) into the down-counter.
  - If req has dropped to 0 by the ARB cycle: go to IDLE, no grant issued.
  - Otherwise → RUN.
- RUN: grant[winner]=1; slot_start[winner]=1 on the first RUN cycle only.
  - The down-counter decrements each cycle; the slot ends when it reaches 0 or when req[winner] is sampled low.
  - On exit: last←winner, slot_cnt←slot_cnt+1 (mod 2^CNT_W), → GAP.
  - Deasserting start during RUN does not abort the slot.
- GAP (exactly 1 cycle): grant=0.
  - start && |req → ARB; else → IDLE.
  - Guarantees at least one grant-free cycle between slots.

Interrupts:
- wrap_in[i] sets irq_pending[i]; irq_clr[i] clears it.
- Set and clear in the same cycle: set wins.
- irq_any follows irq_pending with 1 cycle latency.
- Interrupt logic runs independently of the FSM state.

## Timing
- Request to grant: req and start sampled high at edge N (IDLE) → ARB after N → grant and slot_start visible after edge N+1.
- Slot length: grant is high for exactly max(run_len,1) cycles when req is held high.
- Early end: if req[winner] is sampled low at edge M, grant is 0 after edge M. The slot counts as completed.
- Back-to-back slots with continuous requests repeat every run_len+2 cycles (ARB + RUN + GAP).
- slot_cnt increments on the same edge that drops grant. Wrap: all-ones+1 → 0.
- run_len changes outside ARB have no effect on the current slot.
- wrap_in at edge K → irq_pending after K → irq_any after K+1.

## Test plan
- Reset then single requester: rst high 2 cycles, start=1, req=01, run_len=3 → grant=01 for 3 cycles, slot_start=01 on the first of them, GAP, then repeated slots; slot_cnt=1 after the first slot.
- Round-robin fairness: req=11, run_len=2 → grant sequence 01,(gap),10,(gap),01,…; each grant 2 cycles; period 4 cycles.
- Boundary cases:
  - run_len=0 → one-cycle grants.
  - Drop req[0] in the 2nd cycle of a run_len=8 slot → grant ends after that edge and slot_cnt increments.
  - Hold start low → no ARB.
- Counter wrap: 256 back-to-back run_len=1 slots → slot_cnt returns to 0x00.
- Interrupts:
  - wrap_in=10 → irq_pending=10, then irq_any=1 one cycle later.
  - Same-cycle wrap_in[1]=1 and irq_clr[1]=1 → bit stays 1.
  - irq_clr=10 alone → irq_pending=00.
- Reset mid-slot: assert rst during RUN with grant=10 → grant, slot_start, busy, slot_cnt and irq_pending go to 0 immediately. After release with req=11, grant=01 is issued first.
